central_pu: RTL and testbench

//  Minimal accumulator CPU and top level of the centralPU design. Runs a program held in an internal unified memory.

---
 rtl/central_pu_pkg.sv | 59 +++++
 rtl/central_pu_alu.sv | 61 ++++++
 rtl/central_pu_mem.sv | 32 +++
 rtl/central_pu.sv | 109 ++++++++++
 tb/tb_central_pu.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/central_pu_pkg.sv
// ----------------------------------------------------------------------------
// central_pu_pkg
//   Shared constants for the centralPU accumulator CPU: word/field widths,
//   instruction field positions, opcode values, the FSM state type and two
//   small decode helpers used by the core and its ALU.
//   No ports (package).
// ----------------------------------------------------------------------------
package central_pu_pkg;

    localparam int INSTR_SIZE   = 12;
    localparam int DATA_SIZE    = 8;
    localparam int OPCODE_SIZE  = 4;
    localparam int ADDR_SIZE    = 5;
    localparam int PROGRAM_SIZE = 16;
    localparam int MEM_DEPTH    = 2 ** ADDR_SIZE;

    // Instruction layout: opcode in the top bits, operand below it.
    localparam int OPERAND_W   = INSTR_SIZE - OPCODE_SIZE;
    localparam int OPCODE_MSB  = INSTR_SIZE - 1;
    localparam int OPCODE_LSB  = INSTR_SIZE - OPCODE_SIZE;
    localparam int OPERAND_MSB = OPERAND_W - 1;
    localparam int OPERAND_LSB = 0;

    // First PC value outside the program region.
    localparam logic [DATA_SIZE-1:0] PROGRAM_LIMIT = DATA_SIZE'(PROGRAM_SIZE);

    localparam logic [OPCODE_SIZE-1:0] OP_NOP  = 4'h0;
    localparam logic [OPCODE_SIZE-1:0] OP_LD   = 4'h1;
    localparam logic [OPCODE_SIZE-1:0] OP_ADD  = 4'h2;
    localparam logic [OPCODE_SIZE-1:0] OP_SUB  = 4'h3;
    localparam logic [OPCODE_SIZE-1:0] OP_AND  = 4'h4;
    localparam logic [OPCODE_SIZE-1:0] OP_OR   = 4'h5;
    localparam logic [OPCODE_SIZE-1:0] OP_XOR  = 4'h6;
    localparam logic [OPCODE_SIZE-1:0] OP_NOT  = 4'h7;
    localparam logic [OPCODE_SIZE-1:0] OP_SHL  = 4'h8;
    localparam logic [OPCODE_SIZE-1:0] OP_SHR  = 4'h9;
    localparam logic [OPCODE_SIZE-1:0] OP_ADDI = 4'hA;
    localparam logic [OPCODE_SIZE-1:0] OP_LDI  = 4'hB;
    localparam logic [OPCODE_SIZE-1:0] OP_ST   = 4'hC;
    localparam logic [OPCODE_SIZE-1:0] OP_JMP  = 4'hD;
    localparam logic [OPCODE_SIZE-1:0] OP_BRN  = 4'hE;
    localparam logic [OPCODE_SIZE-1:0] OP_BRZ  = 4'hF;

    // One-hot so that each state bit is directly a phase flag.
    typedef enum logic [1:0] {
        ST_FETCH   = 2'b01,
        ST_EXECUTE = 2'b10
    } cpu_state_t;

    // Opcodes LD..LDI are exactly the ones that update the accumulator.
    function automatic logic writes_acc(input logic [OPCODE_SIZE-1:0] op);
        return (op >= OP_LD) && (op <= OP_LDI);
    endfunction

    function automatic logic [DATA_SIZE-1:0] sext_operand(input logic [OPERAND_W-1:0] operand);
        return DATA_SIZE'($signed(operand));
    endfunction

endpackage

// File: rtl/central_pu_alu.sv
// ----------------------------------------------------------------------------
// central_pu_alu
//   Accumulator register plus the opcode-driven ALU. The accumulator is only
//   written during EXECUTE of an acc-writing opcode (we_alu).
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset (clears acc)
//   i_execute   in   core is in its EXECUTE phase
//   i_opcode    in   opcode of the current instruction
//   i_operand   in   operand field (immediate source)
//   i_mem_data  in   low DATA_SIZE bits of mem[a]
//   o_acc       out  accumulator value
// ----------------------------------------------------------------------------
module central_pu_alu
    import central_pu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_execute,
    input  logic [OPCODE_SIZE-1:0] i_opcode,
    input  logic [OPERAND_W-1:0]   i_operand,
    input  logic [DATA_SIZE-1:0]   i_mem_data,
    output logic [DATA_SIZE-1:0]   o_acc
);

    logic                 we_alu;
    logic [DATA_SIZE-1:0] acc;
    logic [DATA_SIZE-1:0] w_imm;
    logic [DATA_SIZE-1:0] w_result;

    assign we_alu = i_execute && writes_acc(i_opcode);
    assign w_imm  = sext_operand(i_operand);
    assign o_acc  = acc;

    always_comb begin
        w_result = acc;
        case (i_opcode)
            OP_LD:   w_result = i_mem_data;
            OP_ADD:  w_result = acc + i_mem_data;
            OP_SUB:  w_result = acc - i_mem_data;
            OP_AND:  w_result = acc & i_mem_data;
            OP_OR:   w_result = acc | i_mem_data;
            OP_XOR:  w_result = acc ^ i_mem_data;
            OP_NOT:  w_result = ~acc;
            OP_SHL:  w_result = acc << 1;
            OP_SHR:  w_result = {acc[DATA_SIZE-1], acc[DATA_SIZE-1:1]};
            OP_ADDI: w_result = acc + w_imm;
            OP_LDI:  w_result = w_imm;
            default: w_result = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (we_alu) begin
            acc <= w_result;
        end
    end

endmodule

// File: rtl/central_pu_mem.sv
// ----------------------------------------------------------------------------
// central_pu_mem
//   Unified program/data memory, 2**ADDR_SIZE words of INSTR_SIZE bits.
//   Combinational read, synchronous write. Contents are not reset.
// Ports:
//   clk      in   clock
//   i_addr   in   read/write address
//   o_rdata  out  word at i_addr (combinational)
//   i_we     in   write enable, sampled on the rising edge
//   i_wdata  in   word to write
// ----------------------------------------------------------------------------
module central_pu_mem
    import central_pu_pkg::*;
(
    input  logic                  clk,
    input  logic [ADDR_SIZE-1:0]  i_addr,
    output logic [INSTR_SIZE-1:0] o_rdata,
    input  logic                  i_we,
    input  logic [INSTR_SIZE-1:0] i_wdata
);

    logic [INSTR_SIZE-1:0] internal_mem [0:MEM_DEPTH-1];

    assign o_rdata = internal_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            internal_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/central_pu.sv
// ----------------------------------------------------------------------------
// central_pu
//   Minimal accumulator CPU. Each instruction takes two clocks: FETCH loads
//   ir from mem[progr_count], EXECUTE performs it and updates progr_count.
//   A fetch from outside the program region sets out_of_bounds, which halts
//   the core until reset.
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous reset, active-high
//   out_of_bounds  out  registered, sticky halt flag
// ----------------------------------------------------------------------------
module central_pu
    import central_pu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic out_of_bounds
);

    cpu_state_t            r_state;
    logic                  fetch;
    logic                  execute;
    logic [DATA_SIZE-1:0]  progr_count;
    logic [INSTR_SIZE-1:0] ir;

    logic [OPCODE_SIZE-1:0] w_opcode;
    logic [OPERAND_W-1:0]   w_operand;
    logic [DATA_SIZE-1:0]   w_offset;
    logic [DATA_SIZE-1:0]   w_acc;
    logic [DATA_SIZE-1:0]   w_next_pc;
    logic                   w_take_branch;
    logic [ADDR_SIZE-1:0]   w_mem_addr;
    logic [INSTR_SIZE-1:0]  w_mem_rdata;
    logic                   w_mem_we;
    logic [INSTR_SIZE-1:0]  w_mem_wdata;

    // One-hot state: the phase flags are the state flops themselves.
    assign fetch   = r_state[0];
    assign execute = r_state[1];

    assign w_opcode  = ir[OPCODE_MSB:OPCODE_LSB];
    assign w_operand = ir[OPERAND_MSB:OPERAND_LSB];
    assign w_offset  = sext_operand(w_operand);

    // Single memory port: instruction address while fetching, data address
    // (low operand bits) while executing.
    assign w_mem_addr  = execute ? w_operand[ADDR_SIZE-1:0] : progr_count[ADDR_SIZE-1:0];
    // Reset in the EXECUTE cycle of a store must suppress the write.
    assign w_mem_we    = execute && (w_opcode == OP_ST) && !rst;
    assign w_mem_wdata = {{(INSTR_SIZE-DATA_SIZE){1'b0}}, w_acc};

    always_comb begin
        w_take_branch = 1'b0;
        case (w_opcode)
            OP_JMP:  w_take_branch = 1'b1;
            OP_BRN:  w_take_branch = w_acc[DATA_SIZE-1];
            OP_BRZ:  w_take_branch = (w_acc == '0);
            default: w_take_branch = 1'b0;
        endcase
    end

    // PC arithmetic wraps; a branch below 0 lands high and trips the halt.
    assign w_next_pc = w_take_branch ? (progr_count + w_offset)
                                     : (progr_count + DATA_SIZE'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_FETCH;
            progr_count   <= '0;
            ir            <= '0;
            out_of_bounds <= 1'b0;
        end else if (!out_of_bounds) begin
            case (r_state)
                ST_FETCH: begin
                    if (progr_count >= PROGRAM_LIMIT) begin
                        out_of_bounds <= 1'b1;
                    end else begin
                        ir      <= w_mem_rdata;
                        r_state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    progr_count <= w_next_pc;
                    r_state     <= ST_FETCH;
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    central_pu_mem mem0 (
        .clk     (clk),
        .i_addr  (w_mem_addr),
        .o_rdata (w_mem_rdata),
        .i_we    (w_mem_we),
        .i_wdata (w_mem_wdata)
    );

    central_pu_alu alu0 (
        .clk        (clk),
        .rst        (rst),
        .i_execute  (execute),
        .i_opcode   (w_opcode),
        .i_operand  (w_operand),
        .i_mem_data (w_mem_rdata[DATA_SIZE-1:0]),
        .o_acc      (w_acc)
    );

endmodule

// File: tb/tb_central_pu.sv
// ----------------------------------------------------------------------------
// tb_central_pu
//   Bench for central_pu: directed programs plus random programs, each run
//   through an instruction-level reference interpreter. Expected stores go
//   into exp_q; a negedge monitor pops and compares every store the core
//   issues. Halt edge, final acc and final memory are compared afterwards.
// ----------------------------------------------------------------------------
module tb_central_pu;

    localparam int MAX_STEPS = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic out_of_bounds;

    central_pu dut (
        .clk           (clk),
        .rst           (rst),
        .out_of_bounds (out_of_bounds)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // {addr[4:0], word[11:0]} of each expected store, in program order.
    logic [16:0] exp_q[$];
    logic [16:0] mon_got;

    logic [11:0] img[32];
    logic [11:0] model_mem[32];
    logic [7:0]  model_acc;
    int          model_steps;
    bit          model_halted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- store monitor ----------------
    always @(negedge clk) begin
        if (dut.w_mem_we === 1'b1) begin
            mon_got = {dut.w_mem_addr, dut.w_mem_wdata};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_store: got 0x%0h expected no store", mon_got);
            end else begin
                check("store", {15'd0, mon_got}, {15'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- reference interpreter ----------------
    task automatic run_model();
        logic [7:0]  pc, acc, opd, d, nxt;
        logic [3:0]  op;
        logic [4:0]  a;
        logic [11:0] ins;
        logic [16:0] stores[$];
        model_mem    = img;
        pc           = 8'd0;
        acc          = 8'd0;
        model_steps  = 0;
        model_halted = 1'b0;
        while (model_steps < MAX_STEPS) begin
            if (pc >= 8'd16) begin
                model_halted = 1'b1;
                break;
            end
            ins = model_mem[pc[4:0]];
            op  = ins[11:8];
            opd = ins[7:0];
            a   = opd[4:0];
            d   = model_mem[a][7:0];
            nxt = pc + 8'd1;
            case (op)
                4'h1: acc = d;
                4'h2: acc = acc + d;
                4'h3: acc = acc - d;
                4'h4: acc = acc & d;
                4'h5: acc = acc | d;
                4'h6: acc = acc ^ d;
                4'h7: acc = ~acc;
                4'h8: acc = acc * 2;
                4'h9: acc = 8'($signed(acc) >>> 1);
                4'hA: acc = acc + opd;
                4'hB: acc = opd;
                4'hC: begin
                    model_mem[a] = {4'h0, acc};
                    stores.push_back({a, 4'h0, acc});
                end
                4'hD: nxt = pc + opd;
                4'hE: if (acc >= 8'd128) nxt = pc + opd;
                4'hF: if (acc == 8'd0) nxt = pc + opd;
                default: ;
            endcase
            pc = nxt;
            model_steps++;
        end
        model_acc = acc;
        if (model_halted) begin
            foreach (stores[i]) exp_q.push_back(stores[i]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic reset_and_load();
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) dut.mem0.internal_mem[i] = img[i];
        @(posedge clk); #1;
        check("rst_oob", {31'd0, out_of_bounds}, 32'd0);
        check("rst_pc", {24'd0, dut.progr_count}, 32'd0);
        check("rst_fetch", {31'd0, dut.fetch}, 32'd1);
        check("rst_execute", {31'd0, dut.execute}, 32'd0);
        check("rst_acc", {24'd0, dut.alu0.acc}, 32'd0);
        check("rst_we_alu", {31'd0, dut.alu0.we_alu}, 32'd0);
    endtask

    // Releases reset, counts edges to the halt, idles 'hold' clocks, then
    // compares against the model.
    task automatic run_to_halt(input int hold, output int cycles);
        rst    = 1'b0;
        cycles = 0;
        while (cycles < 2 * MAX_STEPS + 10) begin
            @(posedge clk); #1;
            cycles++;
            if (out_of_bounds === 1'b1) break;
        end
        check("halt_edge", cycles, 2 * model_steps + 1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        check("store_queue_drained", exp_q.size(), 0);
        exp_q.delete();
        check("halt_sticky", {31'd0, out_of_bounds}, 32'd1);
        check("final_acc", {24'd0, dut.alu0.acc}, {24'd0, model_acc});
        for (int i = 0; i < 32; i++)
            check($sformatf("mem[%0d]", i), {20'd0, dut.mem0.internal_mem[i]}, {20'd0, model_mem[i]});
    endtask

    task automatic clear_img();
        for (int i = 0; i < 32; i++) img[i] = 12'h000;
    endtask

    task automatic random_img();
        logic [3:0] op;
        logic [7:0] opd;
        for (int i = 0; i < 16; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op >= 4'hD) opd = 8'($urandom_range(0, 8)) - 8'd4;
            else            opd = 8'($urandom_range(0, 255));
            img[i] = {op, opd};
        end
        for (int i = 16; i < 32; i++) img[i] = 12'($urandom);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;

        // ALU program, then sticky halt for 10 clocks, then reset clears it.
        clear_img();
        img[0] = 12'hB0F; img[1] = 12'h214; img[2] = 12'hC15; img[3] = 12'h314;
        img[4] = 12'h614; img[5] = 12'hC16; img[6] = 12'hD0A; img[20] = 12'h003;
        run_model();
        reset_and_load();
        run_to_halt(10, cyc);
        check("alu_mem21", {20'd0, dut.mem0.internal_mem[21]}, 32'h012);
        check("alu_mem22", {20'd0, dut.mem0.internal_mem[22]}, 32'h00C);
        check("alu_halt_edge", cyc, 15);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_clears_oob", {31'd0, out_of_bounds}, 32'd0);

        // Countdown loop.
        clear_img();
        img[0] = 12'hB03; img[1] = 12'hC10; img[2] = 12'hAFF; img[3] = 12'hE0D; img[4] = 12'hDFD;
        run_model();
        reset_and_load();
        run_to_halt(2, cyc);
        check("countdown_halt_edge", cyc, 33);
        check("countdown_mem16", {20'd0, dut.mem0.internal_mem[16]}, 32'h000);

        // Backward jump wrapping below 0.
        clear_img();
        img[0] = 12'hDFF;
        run_model();
        reset_and_load();
        run_to_halt(2, cyc);
        check("wrap_halt_edge", cyc, 3);
        check("wrap_pc", {24'd0, dut.progr_count}, 32'hFF);

        // Reset asserted in the EXECUTE cycle of a store.
        clear_img();
        img[0] = 12'hB05; img[1] = 12'hC10; img[16] = 12'h0AB;
        reset_and_load();
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("midst_in_execute", {31'd0, dut.execute}, 32'd1);
        check("midst_acc", {24'd0, dut.alu0.acc}, 32'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midst_mem16", {20'd0, dut.mem0.internal_mem[16]}, 32'h0AB);
        check("midst_pc", {24'd0, dut.progr_count}, 32'd0);
        check("midst_acc_cleared", {24'd0, dut.alu0.acc}, 32'd0);
        check("midst_fetch", {31'd0, dut.fetch}, 32'd1);

        // Random programs; ones that never leave the program region are skipped.
        for (int t = 0; t < 20; t++) begin
            model_halted = 1'b0;
            for (int tries = 0; tries < 50 && !model_halted; tries++) begin
                random_img();
                run_model();
            end
            if (model_halted) begin
                reset_and_load();
                run_to_halt(2, cyc);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
